rotate_command_sequencer: RTL and testbench
===========================================

# rotate_command_sequencer

Command-driven controller that sits directly upstream of the team's N-bit multimode rotating register and drives its `load`, `mode` and `parallel_in` inputs. It accepts one command at a time over a valid/ready handshake: a data word, a rotate direction and a rotate count. For each command it parallel-loads the word, issues exactly `count` single-bit rotations, then pulses `done`. An optional shadow model checks the register's final value against the expected result.

## Interface
- `N`, 8, word width; must match the downstream register.
- `CW`, 4, width of the rotate count; must satisfy CW ≥ $clog2(N)+1.
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: sequencer can accept a command.
- `cmd_data` input N: word to load.
- `cmd_dir` input 1: rotate direction; 1 = left (toward MSB, MSB wraps to bit 0), 0 = right.
- `cmd_count` input CW: number of single-bit rotations, 0..2^CW-1.
- `reg_load` output 1: drives the register's `load` input.
- `reg_mode` output 2: drives the register's `mode` input; 11 = load, 10 = rotate left, 01 = rotate right, 00 = hold.
- `reg_parallel_in` output N: drives the register's `parallel_in` input.
- `reg_out_fb` input N: feedback from the register's output; used only with the check feature.
- `busy` output 1: a command is in progress.
- `done` output 1: one-cycle pulse marking command completion.
- `mismatch` output 1: sticky result-check failure flag.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE. All outputs are Moore outputs decoded from state and captured registers.
- **IDLE**
  - cmd_ready=1, busy=0, reg_load=0, reg_mode=00.
  - On cmd_valid&&cmd_ready, capture data, dir and count, then go to LOAD.
- **LOAD**
  - reg_load=1, reg_mode=11, reg_parallel_in=captured data.
  - Next state: SHIFT if count≠0, else DONE.
- **SHIFT**
  - reg_load=1, reg_mode=10 if dir=1, else 01.
  - The remaining-count register decrements each cycle; exit to DONE after the cycle in which remaining=1.
- **DONE**
  - done=1, reg_load=0, reg_mode=00.
  - Next state: IDLE.
- busy=1 in LOAD, SHIFT and DONE. cmd_ready=0 in those states, so commands never overlap.
- reg_parallel_in holds the captured data in all states and is 0 after reset.
- count ≥ N is legal and performs full wrap-around rotations. Example: count=N returns the original word.
- cmd fields are ignored when no handshake occurs. cmd_valid may drop without acceptance.
- **Reset** in any state, including mid-SHIFT:
  - state returns to IDLE.
  - cmd_ready=1 once reset deasserts.
  - busy, done, reg_load, mismatch are 0; reg_mode=00; reg_parallel_in=0; internal registers are 0.
  - The downstream register is reset by the same signal.

## Timing
- Accept at edge E0. LOAD occupies cycle E0–E1; the register holds the word after E1.
- Each SHIFT cycle rotates the register at its closing edge. The final value is present after edge E1+count.
- done is high during cycle E1+count to E2+count. reg_out_fb equals the final result during that cycle.
- cmd_ready is low for count+2 cycles. The next command can be accepted at edge E2+count, giving back-to-back throughput of one command per count+2 cycles.
- Latency from acceptance to done is count+1 cycles (done is asserted after edge E1+count).

## Configuration
- Macro: `ROTATE_SHADOW_CHECK_EN`.
- **Defined**
  - An internal shadow word loads and rotates in lockstep with the issued modes.
  - In DONE, if reg_out_fb ≠ shadow, mismatch is set.
  - mismatch stays set until the next accepted command or reset.
- **Undefined**
  - No shadow logic is built.
  - mismatch is tied 0 and reg_out_fb is unused.
  - Port list is unchanged.

## Structure
- Shared package holds:
  - mode constants MODE_HOLD=2'b00, MODE_ROR=2'b01, MODE_ROL=2'b10, MODE_LOAD=2'b11.
  - the FSM state typedef (IDLE, LOAD, SHIFT, DONE).
- One sub-module, `rotate_shadow`: an N-bit load/rotate model driven by reg_mode, instantiated only under `ROTATE_SHADOW_CHECK_EN`.

## Test plan
All scenarios drive the downstream register instantiated with the same N.
- data=8'hA5, dir=1, count=1 -> reg_out=8'h4B during done; cmd_ready low 3 cycles; mismatch=0.
- data=8'hA5, dir=0, count=1 -> reg_out=8'hD2; then data=8'h81, dir=0, count=3 accepted on the edge after done -> reg_out=8'h30.
- count=0, data=8'h3C -> only the LOAD cycle is issued; done pulses in the cycle after E1; reg_out=8'h3C.
- data=8'hA5, count=8 (either dir) -> 8 SHIFT cycles; reg_out=8'hA5; busy high 10 cycles; count=15, dir=1 -> reg_out=8'hD2.
- Assert reset during the 3rd SHIFT cycle of a count=6 command -> all outputs and reg_out read 0 immediately; cmd_ready=1 after deassert; a new command completes normally.
- With `ROTATE_SHADOW_CHECK_EN` defined, force reg_out_fb=8'h00 for data=8'hA5, count=2 -> mismatch=1 after DONE; mismatch clears when the next command is accepted.

Source files
------------

// File: rtl/rotate_command_sequencer_pkg.sv
// Shared mode encodings and sequencer state type for the rotate command sequencer.
// Mode values match the downstream rotating register's mode input.
package rotate_command_sequencer_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_ROR  = 2'b01;
    localparam logic [1:0] MODE_ROL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/rotate_command_sequencer_shadow.sv
// rotate_shadow: N-bit load/rotate model that follows the issued register modes.
// Latency: updates at the same edge as the real register; built only with ROTATE_SHADOW_CHECK_EN.
`ifdef ROTATE_SHADOW_CHECK_EN
module rotate_shadow
    import rotate_command_sequencer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   mode,
    input  logic [N-1:0] parallel_in,
    output logic [N-1:0] shadow
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
        end else begin
            case (mode)
                MODE_LOAD: shadow <= parallel_in;
                MODE_ROL:  shadow <= {shadow[N-2:0], shadow[N-1]};
                MODE_ROR:  shadow <= {shadow[0], shadow[N-1:1]};
                default:   shadow <= shadow;
            endcase
        end
    end

endmodule
`endif

// File: rtl/rotate_command_sequencer.sv
// Purpose: loads a word into the downstream rotating register, issues count rotations, pulses done.
// Latency: done asserted count+1 cycles after acceptance; cmd_ready low for count+2 cycles.
// Backpressure: one command in flight; cmd_ready only in IDLE. Optional check: ROTATE_SHADOW_CHECK_EN.
module rotate_command_sequencer
    import rotate_command_sequencer_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [N-1:0]  cmd_data,
    input  logic          cmd_dir,
    input  logic [CW-1:0] cmd_count,
    output logic          reg_load,
    output logic [1:0]    reg_mode,
    output logic [N-1:0]  reg_parallel_in,
    input  logic [N-1:0]  reg_out_fb,
    output logic          busy,
    output logic          done,
    output logic          mismatch
);

    seq_state_t    state_q, state_d;
    logic [N-1:0]  data_q;
    logic          dir_q;
    logic [CW-1:0] remaining_q;
    logic          accept;

    assign accept = (state_q == IDLE) && cmd_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            dir_q       <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q      <= cmd_data;
                dir_q       <= cmd_dir;
                remaining_q <= cmd_count;
            end else if (state_q == SHIFT) begin
                remaining_q <= remaining_q - CW'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        reg_load  = 1'b0;
        reg_mode  = MODE_HOLD;
        case (state_q)
            IDLE: begin
                // Held low while reset is asserted so every output reads 0 in reset.
                cmd_ready = !reset;
                busy      = 1'b0;
                if (cmd_valid) state_d = LOAD;
            end
            LOAD: begin
                reg_load = 1'b1;
                reg_mode = MODE_LOAD;
                state_d  = (remaining_q != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                reg_load = 1'b1;
                reg_mode = dir_q ? MODE_ROL : MODE_ROR;
                if (remaining_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign reg_parallel_in = data_q;

`ifdef ROTATE_SHADOW_CHECK_EN
    logic [N-1:0] shadow;
    logic         mismatch_q;

    rotate_shadow #(.N(N)) u_shadow (
        .clk         (clk),
        .reset       (reset),
        .mode        (reg_mode),
        .parallel_in (data_q),
        .shadow      (shadow)
    );

    // Sticky until the next command is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mismatch_q <= 1'b0;
        end else if (accept) begin
            mismatch_q <= 1'b0;
        end else if ((state_q == DONE) && (reg_out_fb != shadow)) begin
            mismatch_q <= 1'b1;
        end
    end

    assign mismatch = mismatch_q;
`else
    logic unused_fb;
    assign unused_fb = ^reg_out_fb;
    assign mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_rotate_command_sequencer.sv
// Bench for rotate_command_sequencer: downstream register model, per-cycle reference model,
// directed scenarios plus randomized commands.
module tb_rotate_command_sequencer;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [N-1:0]  cmd_data = '0;
    logic          cmd_dir = 1'b0;
    logic [CW-1:0] cmd_count = '0;
    logic          reg_load;
    logic [1:0]    reg_mode;
    logic [N-1:0]  reg_parallel_in;
    logic [N-1:0]  reg_out_fb;
    logic          busy;
    logic          done;
    logic          mismatch;

    logic [N-1:0]  reg_q;
    logic          force_zero = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rotate_command_sequencer #(.N(N), .CW(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_data        (cmd_data),
        .cmd_dir         (cmd_dir),
        .cmd_count       (cmd_count),
        .reg_load        (reg_load),
        .reg_mode        (reg_mode),
        .reg_parallel_in (reg_parallel_in),
        .reg_out_fb      (reg_out_fb),
        .busy            (busy),
        .done            (done),
        .mismatch        (mismatch)
    );

    // Downstream multimode rotating register.
    always @(posedge clk or posedge reset) begin
        if (reset) reg_q <= '0;
        else if (reg_load) begin
            case (reg_mode)
                2'b11: reg_q <= reg_parallel_in;
                2'b10: reg_q <= {reg_q[N-2:0], reg_q[N-1]};
                2'b01: reg_q <= {reg_q[0], reg_q[N-1:1]};
                default: reg_q <= reg_q;
            endcase
        end
    end
    assign reg_out_fb = force_zero ? '0 : reg_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [N-1:0] rot(input logic [N-1:0] x, input logic d, input int c);
        int k;
        logic [2*N-1:0] w;
        k = c % N;
        w = {x, x};
        if (k == 0) return x;
        if (d) return w[2*N-1-k -: N];
        return w[k +: N];
    endfunction

    // Reference model: position within the current command, counted in cycles.
    bit           m_active = 0;
    int           m_k = 0;
    int           m_c = 0;
    logic         m_dir = 0;
    logic [N-1:0] m_data = '0;
    logic         m_mis = 0;
    logic [N-1:0] last_done_out = '0;
    int           rl_cnt = 0, last_rl = 0;
    int           bz_cnt = 0, last_bz = 0;

    always @(negedge clk) begin
        logic       e_ready, e_busy, e_done, e_load;
        logic [1:0] e_mode;
        logic [N-1:0] e_res;
        if (reset) begin
            check("rst_ready", cmd_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_load", reg_load, 0);
            check("rst_mode", reg_mode, 0);
            check("rst_pin", reg_parallel_in, 0);
            check("rst_mismatch", mismatch, 0);
            m_active = 0; m_k = 0; m_c = 0; m_dir = 0; m_data = '0; m_mis = 0;
            rl_cnt = 0; bz_cnt = 0;
        end else begin
            e_ready = !m_active;
            e_busy  = m_active;
            e_load  = m_active && (m_k <= m_c);
            e_done  = m_active && (m_k == m_c + 1);
            e_mode  = !e_load ? 2'b00 : (m_k == 0) ? 2'b11 : (m_dir ? 2'b10 : 2'b01);
            e_res   = rot(m_data, m_dir, m_c);
            check("cmd_ready", cmd_ready, e_ready);
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("reg_load", reg_load, e_load);
            check("reg_mode", reg_mode, e_mode);
            check("reg_parallel_in", reg_parallel_in, m_data);
            check("mismatch", mismatch, m_mis);
            if (e_done) begin
                last_done_out = reg_out_fb;
                if (!force_zero) check("reg_out_at_done", reg_out_fb, e_res);
            end
            if (!cmd_ready) rl_cnt++;
            else if (rl_cnt != 0) begin last_rl = rl_cnt; rl_cnt = 0; end
            if (busy) bz_cnt++;
            else if (bz_cnt != 0) begin last_bz = bz_cnt; bz_cnt = 0; end
            // Advance to the state expected for the next cycle.
            if (!m_active) begin
                if (cmd_valid) begin
                    m_active = 1; m_k = 0; m_c = int'(cmd_count);
                    m_dir = cmd_dir; m_data = cmd_data; m_mis = 0;
                end
            end else if (e_done) begin
                m_active = 0;
`ifdef ROTATE_SHADOW_CHECK_EN
                if ((force_zero ? '0 : e_res) != e_res) m_mis = 1;
`endif
            end else begin
                m_k++;
            end
        end
    end

    task automatic send(input logic [N-1:0] d, input logic dir, input int c);
        bit ok;
        ok = 0;
        cmd_valid = 1; cmd_data = d; cmd_dir = dir; cmd_count = CW'(c);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) check("handshake_timeout", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 0;
        cmd_data = N'($urandom); cmd_dir = 1'($urandom); cmd_count = CW'($urandom);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        if (!ok) check("done_timeout", done, 1);
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        check("ready_after_reset", cmd_ready, 1);
        @(posedge clk); #1;

        send(8'hA5, 1, 1); wait_done(); settle();
        check("rol1_value", last_done_out, 8'h4B);
        check("rol1_ready_low", last_rl, 3);
        check("rol1_mismatch", mismatch, 0);

        send(8'hA5, 0, 1); wait_done();
        check("ror1_value", last_done_out, 8'hD2);
        send(8'h81, 0, 3); wait_done();
        check("ror3_value", last_done_out, 8'h30);

        send(8'h3C, 0, 0); wait_done(); settle();
        check("cnt0_value", last_done_out, 8'h3C);
        check("cnt0_ready_low", last_rl, 2);

        send(8'hA5, 0, 8); wait_done(); settle();
        check("cnt8_value", last_done_out, 8'hA5);
        check("cnt8_busy", last_bz, 10);
        send(8'hA5, 1, 15); wait_done();
        check("cnt15_value", last_done_out, 8'hD2);

        // Reset during the third SHIFT cycle of a count=6 command.
        send(8'h5A, 1, 6);
        repeat (3) @(posedge clk);
        #1 reset = 1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_mode", reg_mode, 0);
        check("midrst_load", reg_load, 0);
        check("midrst_pin", reg_parallel_in, 0);
        check("midrst_reg_out", reg_out_fb, 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("midrst_ready", cmd_ready, 1);
        send(8'hC3, 1, 2); wait_done();
        check("post_rst_value", last_done_out, 8'h0F);

`ifdef ROTATE_SHADOW_CHECK_EN
        force_zero = 1;
        send(8'hA5, 1, 2); wait_done(); settle();
        force_zero = 0;
        check("shadow_mismatch_set", mismatch, 1);
        send(8'h11, 0, 1);
        check("shadow_mismatch_clr", mismatch, 0);
        wait_done();
`endif

        for (int i = 0; i < 40; i++) begin
            send(N'($urandom), 1'($urandom), $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                // Stray valid while busy must be ignored.
                cmd_valid = 1;
                @(posedge clk); #1 cmd_valid = 0;
            end
            wait_done();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        settle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
